avalon_st_result_assembler: RTL
===============================

Name: avalon_st_result_assembler

Overview:
Avalon-ST sink that sits directly downstream of the slave wrapper's return stream, in the master-side receive path. It collects an 8-bit SOP/EOP-framed byte packet and reassembles it into one wide result word (the 2*SZ product). It presents that word on a valid/ready output with a length/error indication. Ready latency 0 on the sink side.

Parameters:
DSZ, 8, stream data width in bits (one beat = one byte)
OSZ, 64, assembled result width in bits; must be a multiple of DSZ
NBYTES, OSZ/DSZ, derived localparam; expected beats per packet
LW, $clog2(NBYTES+2), derived localparam; width of the beat counter and out_len

Ports:
clk  in  1  single clock; all logic rising-edge
_rst  in  1  asynchronous, active-high reset
in_data  in  DSZ  stream byte
in_valid  in  1  source has a beat
in_ready  out  1  sink accepts the beat this cycle
in_sop  in  1  first beat of a packet
in_eop  in  1  last beat of a packet
out_data  out  OSZ  assembled word
out_valid  out  1  out_data/out_len/out_err are valid
out_ready  in  1  consumer accepts the word
out_len  out  LW  beats received, saturating at NBYTES+1
out_err  out  1  packet length differed from NBYTES
orphan_cnt  out  8  saturating count of discarded beats and abandoned packets

Behaviour:
- Reset (async assert, sync release) drives state to IDLE:
  - out_data=0, out_valid=0, out_len=0, out_err=0, orphan_cnt=0
  - in_ready=0 while _rst is high
- Accept condition: a beat is accepted iff in_valid && in_ready.
- in_ready = !_rst && (state != HOLD). It is combinational from state, with no dependence on in_valid.
- Byte order is little-endian: beat k of a packet lands in out_data[k*DSZ +: DSZ].
- States:
  - IDLE:
    - Accepted beat without in_sop: discarded; orphan_cnt++ (saturates at 255).
    - Accepted beat with in_sop: out_data cleared to 0 except byte 0 = in_data; count=1.
      - If in_eop is also set: go to HOLD.
      - Otherwise: go to COLLECT.
  - COLLECT:
    - Accepted beat without in_sop:
      - If count < NBYTES: byte is written at index count.
      - If count >= NBYTES: byte is dropped; data is unchanged.
      - count increments, saturating at NBYTES+1.
      - If in_eop: go to HOLD.
    - Accepted beat with in_sop: current packet is abandoned; orphan_cnt++. The beat starts a new packet exactly as in IDLE, including SOP+EOP going to HOLD.
  - HOLD:
    - out_valid=1; out_len = final count; out_err = (count != NBYTES).
    - out_data, out_len and out_err are stable until out_valid && out_ready.
    - On that handshake: go to IDLE, out_valid=0 next cycle, in_ready=1 next cycle.
- Latency: EOP accepted at edge t gives out_valid=1 after edge t (visible in cycle t+1). Minimum packet-to-packet gap is one cycle of in_ready=0 (the HOLD cycle).
- Unfilled upper bytes of a short packet read 0.
- Overlong packets keep the first NBYTES bytes, report out_len=NBYTES+1 and set out_err=1.
- in_data, in_sop and in_eop are ignored when no beat is accepted.
- Reset mid-packet or in HOLD: immediate return to reset values. The partial or pending word is lost and not counted in orphan_cnt.
- out_ready asserted with out_valid=0 has no effect.

Test Plan:
1. Nominal 8-beat packet 02,00,00,00,00,00,00,00 (SOP on beat 0, EOP on beat 7), out_ready=1 -> out_valid high for exactly 1 cycle, beginning the cycle after the EOP beat. out_data=64'h2, out_len=8, out_err=0, orphan_cnt=0.
2. Backpressure: packet bytes 01..08, out_ready=0 for 5 cycles then 1 -> out_data=64'h0807060504030201 held stable and in_ready=0 throughout. Return to IDLE after the handshake; an immediate second packet is then assembled correctly.
3. Short packet of 3 beats AA,BB,CC -> out_data=64'h0000000000CCBBAA, out_len=3, out_err=1. Single SOP+EOP beat 5A -> out_data=64'h5A, out_len=1, out_err=1.
4. Overlong 10-beat packet 01..0A -> out_data=64'h0807060504030201, out_len=9, out_err=1.
5. Orphans: 2 beats without SOP in IDLE, then SOP at beat 3 of an open packet followed by a clean 8-beat packet -> orphan_cnt=3. Output is only the clean packet, with out_err=0.
6. Assert _rst during beat 4 of a packet and during HOLD -> outputs return to 0 asynchronously; in_ready=0 while _rst is high. After release, a fresh nominal packet yields a correct result.

Source files
------------

// File: rtl/avalon_st_result_assembler.sv
// Reassembles an SOP/EOP-framed byte stream into one little-endian wide result word.
// The word is presented on a valid/ready output together with the beat count and a length-error flag.
module avalon_st_result_assembler #(
  parameter  int DSZ    = 8,
  parameter  int OSZ    = 64,
  localparam int NBYTES = OSZ / DSZ,
  localparam int LW     = $clog2(NBYTES + 2)
) (
  input  logic           clk,
  input  logic           _rst,
  input  logic [DSZ-1:0] in_data,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_sop,
  input  logic           in_eop,
  output logic [OSZ-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [LW-1:0]  out_len,
  output logic           out_err,
  output logic [7:0]     orphan_cnt
);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t         state, state_next;
  logic [OSZ-1:0] data_q, data_d;
  logic [LW-1:0]  count_q, count_d;
  logic [7:0]     orphan_q, orphan_d;
  logic           accept;

  assign in_ready = !_rst && (state != HOLD);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge _rst) begin
    if (_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // An SOP seen while collecting abandons the open packet and restarts, so COLLECT only leaves on EOP.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && in_sop) begin
          state_next = in_eop ? HOLD : COLLECT;
        end
      end
      COLLECT: begin
        if (accept && in_eop) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid  = (state == HOLD);
    out_err    = (state == HOLD) && (count_q != LW'(NBYTES));
    out_data   = data_q;
    out_len    = count_q;
    orphan_cnt = orphan_q;
  end

  always_comb begin
    data_d   = data_q;
    count_d  = count_q;
    orphan_d = orphan_q;
    if (accept) begin
      if (in_sop) begin
        data_d            = '0;
        data_d[DSZ-1:0]   = in_data;
        count_d           = LW'(1);
        if (state == COLLECT && orphan_q != 8'hFF) begin
          orphan_d = orphan_q + 8'd1;
        end
      end else if (state == COLLECT) begin
        // Beats beyond NBYTES match no lane here and are dropped, but still counted.
        for (int k = 0; k < NBYTES; k++) begin
          if (count_q == LW'(k)) begin
            data_d[k*DSZ +: DSZ] = in_data;
          end
        end
        if (count_q < LW'(NBYTES + 1)) begin
          count_d = count_q + LW'(1);
        end
      end else if (orphan_q != 8'hFF) begin
        orphan_d = orphan_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge _rst) begin
    if (_rst) begin
      data_q   <= '0;
      count_q  <= '0;
      orphan_q <= '0;
    end else begin
      data_q   <= data_d;
      count_q  <= count_d;
      orphan_q <= orphan_d;
    end
  end

endmodule
